// File: rtl/usr_shift_sequencer.sv
// Command sequencer for a WIDTH-bit universal shift register: turns one handshaken
// command into a run of sel/p_in/serial-input cycles followed by a one-cycle done pulse.
module usr_shift_sequencer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rest,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             cmd_rot,
  input  logic             cmd_fill,
  input  logic             s_right_out,
  input  logic             s_left_out,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] p_in,
  output logic             s_right,
  output logic             s_left,
  output logic             busy,
  output logic             done
);

  localparam int unsigned RemW = CNT_W + 1;
  localparam logic [1:0] OpLoad = 2'd3;
  localparam logic [RemW-1:0] RemOne = RemW'(1);
  // A zero count means a full 2^CNT_W shifts, hence the extra remaining bit.
  localparam logic [RemW-1:0] RemFull = RemW'(1) << CNT_W;

  typedef enum logic [1:0] {
    StIdle,
    StActive,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [RemW-1:0]  remaining_q, remaining_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             rot_q, rot_d;
  logic             fill_q, fill_d;
  logic [1:0]       sel_q, sel_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept;

  assign cmd_ready = (state_q == StIdle);
  assign accept    = cmd_valid & cmd_ready;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    op_d        = op_q;
    data_d      = data_q;
    rot_d       = rot_q;
    fill_d      = fill_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StActive;
          op_d    = cmd_op;
          data_d  = cmd_data;
          rot_d   = cmd_rot;
          fill_d  = cmd_fill;
          if (cmd_op == OpLoad) begin
            remaining_d = RemOne;
          end else if (cmd_count == '0) begin
            remaining_d = RemFull;
          end else begin
            remaining_d = RemW'(cmd_count);
          end
        end
      end
      StActive: begin
        remaining_d = remaining_q - RemOne;
        if (remaining_q == RemOne) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_comb begin
    sel_d  = (state_d == StActive) ? op_d : 2'd0;
    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (rest) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      op_q        <= 2'd0;
      data_q      <= '0;
      rot_q       <= 1'b0;
      fill_q      <= 1'b0;
      sel_q       <= 2'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      op_q        <= op_d;
      data_q      <= data_d;
      rot_q       <= rot_d;
      fill_q      <= fill_d;
      sel_q       <= sel_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Rotate loopback is combinational so it follows the register every cycle.
  always_comb begin
    s_right = 1'b0;
    s_left  = 1'b0;
    if (state_q == StActive) begin
      s_right = rot_q ? s_left_out  : fill_q;
      s_left  = rot_q ? s_right_out : fill_q;
    end
  end

  assign sel  = sel_q;
  assign p_in = data_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_usr_shift_sequencer.sv
// Bench for usr_shift_sequencer: a 4-bit universal shift register model closes the loop,
// expected register traces and done latencies go through a scoreboard queue.
module tb_usr_shift_sequencer;

  logic       clk;
  logic       rest;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic [2:0] cmd_count;
  logic       cmd_rot;
  logic       cmd_fill;
  logic       s_right_out;
  logic       s_left_out;
  logic [1:0] sel;
  logic [3:0] p_in;
  logic       s_right;
  logic       s_left;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  logic [3:0] exp_trace[$];
  int         exp_lat[$];
  logic [3:0] trace[$];
  logic [1:0] obs_sel[$];
  logic       obs_sr[$];
  logic       obs_sl[$];
  logic [3:0] obs_before[$];

  usr_shift_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
    .clk        (clk),
    .rest       (rest),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .cmd_count  (cmd_count),
    .cmd_rot    (cmd_rot),
    .cmd_fill   (cmd_fill),
    .s_right_out(s_right_out),
    .s_left_out (s_left_out),
    .sel        (sel),
    .p_in       (p_in),
    .s_right    (s_right),
    .s_left     (s_left),
    .busy       (busy),
    .done       (done)
  );

  // Universal shift register driven by the sequencer.
  logic [3:0] sr_q;
  assign s_right_out = sr_q[3];
  assign s_left_out  = sr_q[0];
  always_ff @(posedge clk) begin
    if (rest) sr_q <= 4'h0;
    else begin
      case (sel)
        2'd1:    sr_q <= {s_right, sr_q[3:1]};
        2'd2:    sr_q <= {sr_q[2:0], s_left};
        2'd3:    sr_q <= p_in;
        default: sr_q <= sr_q;
      endcase
    end
  end

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [3:0] sr_step(logic [3:0] r, logic [1:0] op, logic [3:0] d,
                                         logic rot, logic fill);
    case (op)
      2'd1:    return {(rot ? r[0] : fill), r[3:1]};
      2'd2:    return {r[2:0], (rot ? r[3] : fill)};
      2'd3:    return d;
      default: return r;
    endcase
  endfunction

  // Issues one command, optionally pushes expectations, and records what the DUT does.
  task automatic run_cmd(input logic [1:0] op, input logic [3:0] data, input logic [2:0] cnt,
                         input logic rot, input logic fill, input bit sb, output int lat,
                         output logic busy_dn, output logic [3:0] pin_dn, output logic [1:0] sel_dn,
                         output logic rdy_after, output logic busy_after);
    int n;
    int steps;
    logic [3:0] r;
    trace.delete(); obs_sel.delete(); obs_sr.delete(); obs_sl.delete(); obs_before.delete();
    cmd_op = op; cmd_data = data; cmd_count = cnt; cmd_rot = rot; cmd_fill = fill;
    cmd_valid = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    steps = (op == 2'd3) ? 1 : ((cnt == 3'd0) ? 8 : int'(cnt));
    if (sb) begin
      r = sr_q;
      for (int i = 0; i < steps; i++) begin
        r = sr_step(r, op, data, rot, fill);
        exp_trace.push_back(r);
      end
      exp_lat.push_back(steps + 1);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin
      obs_sel.push_back(sel); obs_sr.push_back(s_right); obs_sl.push_back(s_left);
      obs_before.push_back(sr_q);
      @(posedge clk); #1; lat++;
      trace.push_back(sr_q);
    end
    busy_dn = busy; pin_dn = p_in; sel_dn = sel;
    @(posedge clk); #1;
    rdy_after = cmd_ready; busy_after = busy;
  endtask

  task automatic test_reset();
    rest = 1'b1; cmd_valid = 1'b1; cmd_op = 2'd3; cmd_data = 4'hF; cmd_count = 3'd2;
    repeat (3) begin @(posedge clk); #1; end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
    total++; if (sel !== 2'd0) begin bad++; $display("FAIL reset_sel: got %0d want 0", sel); end
    total++; if (p_in !== 4'h0) begin bad++; $display("FAIL reset_pin: got %h want 0", p_in); end
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL reset_busy_done: got %b want 00", {busy, done}); end
    total++; if ({s_right, s_left} !== 2'b00) begin bad++; $display("FAIL reset_serial: got %b want 00", {s_right, s_left}); end
    cmd_valid = 1'b0; rest = 1'b0;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0 || p_in !== 4'h0) begin bad++; $display("FAIL reset_release: busy=%b p_in=%h want 0/0", busy, p_in); end
  endtask

  task automatic test_load();
    int lat; int el; logic bd, ra, ba; logic [3:0] pd, e; logic [1:0] sd;
    run_cmd(2'd3, 4'hA, 3'd0, 1'b0, 1'b0, 1'b1, lat, bd, pd, sd, ra, ba);
    el = exp_lat.pop_front();
    total++; if (lat !== el) begin bad++; $display("FAIL load_latency: got %0d want %0d", lat, el); end
    for (int i = 0; i < el - 1; i++) begin
      e = exp_trace.pop_front();
      total++; if (i >= trace.size() || trace[i] !== e) begin bad++; $display("FAIL load_reg: step %0d want %h", i, e); end
    end
    foreach (obs_sel[i]) begin
      total++; if (obs_sel[i] !== 2'd3) begin bad++; $display("FAIL load_sel: got %0d want 3", obs_sel[i]); end
    end
    total++; if (bd !== 1'b1 || sd !== 2'd0) begin bad++; $display("FAIL load_done_state: busy=%b sel=%0d want 1/0", bd, sd); end
    total++; if (pd !== 4'hA) begin bad++; $display("FAIL load_pin: got %h want a", pd); end
    total++; if (ra !== 1'b1 || ba !== 1'b0) begin bad++; $display("FAIL load_after: ready=%b busy=%b want 1/0", ra, ba); end
  endtask

  task automatic test_shift_fill();
    int lat; int el; logic bd, ra, ba; logic [3:0] pd, e; logic [1:0] sd;
    run_cmd(2'd3, 4'hC, 3'd0, 1'b0, 1'b0, 1'b0, lat, bd, pd, sd, ra, ba);
    run_cmd(2'd1, 4'h0, 3'd2, 1'b0, 1'b1, 1'b1, lat, bd, pd, sd, ra, ba);
    el = exp_lat.pop_front();
    total++; if (lat !== el) begin bad++; $display("FAIL fill_latency: got %0d want %0d", lat, el); end
    for (int i = 0; i < el - 1; i++) begin
      e = exp_trace.pop_front();
      total++; if (i >= trace.size() || trace[i] !== e) begin bad++; $display("FAIL fill_reg: step %0d want %h", i, e); end
    end
    foreach (obs_sel[i]) begin
      total++; if (obs_sel[i] !== 2'd1 || obs_sr[i] !== 1'b1 || obs_sl[i] !== 1'b1) begin
        bad++; $display("FAIL fill_drive: sel=%0d sr=%b sl=%b want 1/1/1", obs_sel[i], obs_sr[i], obs_sl[i]);
      end
    end
    total++; if ({s_right, s_left} !== 2'b00) begin bad++; $display("FAIL fill_idle_serial: got %b want 00", {s_right, s_left}); end
  endtask

  task automatic test_rotate_left();
    int lat; int el; logic bd, ra, ba; logic [3:0] pd, e, b; logic [1:0] sd;
    run_cmd(2'd3, 4'h9, 3'd0, 1'b0, 1'b0, 1'b0, lat, bd, pd, sd, ra, ba);
    run_cmd(2'd2, 4'h0, 3'd4, 1'b1, 1'b0, 1'b1, lat, bd, pd, sd, ra, ba);
    el = exp_lat.pop_front();
    total++; if (lat !== el) begin bad++; $display("FAIL rotl_latency: got %0d want %0d", lat, el); end
    for (int i = 0; i < el - 1; i++) begin
      e = exp_trace.pop_front();
      total++; if (i >= trace.size() || trace[i] !== e) begin bad++; $display("FAIL rotl_reg: step %0d want %h", i, e); end
    end
    foreach (obs_sl[i]) begin
      b = obs_before[i];
      total++; if (obs_sl[i] !== b[3]) begin bad++; $display("FAIL rotl_loopback: got %b want %b", obs_sl[i], b[3]); end
    end
  endtask

  task automatic test_count_zero();
    int lat; int el; logic bd, ra, ba; logic [3:0] pd, e, b; logic [1:0] sd;
    run_cmd(2'd3, 4'h1, 3'd0, 1'b0, 1'b0, 1'b0, lat, bd, pd, sd, ra, ba);
    run_cmd(2'd1, 4'h0, 3'd0, 1'b1, 1'b0, 1'b1, lat, bd, pd, sd, ra, ba);
    el = exp_lat.pop_front();
    total++; if (lat !== el) begin bad++; $display("FAIL cnt0_latency: got %0d want %0d", lat, el); end
    for (int i = 0; i < el - 1; i++) begin
      e = exp_trace.pop_front();
      total++; if (i >= trace.size() || trace[i] !== e) begin bad++; $display("FAIL cnt0_reg: step %0d want %h", i, e); end
    end
    foreach (obs_sr[i]) begin
      b = obs_before[i];
      total++; if (obs_sr[i] !== b[0] || obs_sel[i] !== 2'd1) begin
        bad++; $display("FAIL cnt0_drive: sr=%b sel=%0d want %b/1", obs_sr[i], obs_sel[i], b[0]);
      end
    end
  endtask

  task automatic test_hold();
    int lat; int el; logic bd, ra, ba; logic [3:0] pd, e; logic [1:0] sd;
    run_cmd(2'd0, 4'h0, 3'd3, 1'b0, 1'b1, 1'b1, lat, bd, pd, sd, ra, ba);
    el = exp_lat.pop_front();
    total++; if (lat !== el) begin bad++; $display("FAIL hold_latency: got %0d want %0d", lat, el); end
    for (int i = 0; i < el - 1; i++) begin
      e = exp_trace.pop_front();
      total++; if (i >= trace.size() || trace[i] !== e) begin bad++; $display("FAIL hold_reg: step %0d want %h", i, e); end
    end
    foreach (obs_sel[i]) begin
      total++; if (obs_sel[i] !== 2'd0) begin bad++; $display("FAIL hold_sel: got %0d want 0", obs_sel[i]); end
    end
  endtask

  task automatic test_back_pressure();
    int first; int n; int lat; int el; logic [3:0] e;
    cmd_op = 2'd1; cmd_data = 4'h3; cmd_count = 3'd5; cmd_rot = 1'b0; cmd_fill = 1'b0;
    cmd_valid = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    cmd_op = 2'd3; cmd_data = 4'h5;
    first = 0;
    for (int i = 1; i <= 20 && first == 0; i++) begin
      if (cmd_ready === 1'b1) first = i;
      else begin @(posedge clk); #1; end
    end
    total++; if (first !== 7) begin bad++; $display("FAIL bp_ready_cycle: got %0d want 7", first); end
    exp_trace.push_back(4'h5);
    exp_lat.push_back(2);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    el = exp_lat.pop_front();
    e = exp_trace.pop_front();
    total++; if (lat !== el) begin bad++; $display("FAIL bp_latency: got %0d want %0d", lat, el); end
    total++; if (sr_q !== e || p_in !== e) begin bad++; $display("FAIL bp_reg: reg=%h p_in=%h want %h", sr_q, p_in, e); end
    @(posedge clk); #1;
    total++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL bp_after: busy=%b ready=%b want 0/1", busy, cmd_ready); end
  endtask

  task automatic test_reset_mid();
    int n; int seen;
    cmd_op = 2'd1; cmd_data = 4'h7; cmd_count = 3'd0; cmd_rot = 1'b1; cmd_fill = 1'b0;
    cmd_valid = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    total++; if (sel !== 2'd1 || busy !== 1'b1) begin bad++; $display("FAIL mid_active: sel=%0d busy=%b want 1/1", sel, busy); end
    rest = 1'b1;
    @(posedge clk); #1;
    rest = 1'b0;
    total++; if (sel !== 2'd0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL mid_reset: sel=%0d busy=%b ready=%b want 0/0/1", sel, busy, cmd_ready);
    end
    total++; if (p_in !== 4'h0 || {s_right, s_left} !== 2'b00) begin
      bad++; $display("FAIL mid_reset_outs: p_in=%h serial=%b want 0/00", p_in, {s_right, s_left});
    end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (done !== 1'b0 || busy !== 1'b0) seen++;
      @(posedge clk); #1;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL mid_no_done: %0d active cycles want 0", seen); end
  endtask

  initial begin
    clk = 1'b0; rest = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = 4'h0;
    cmd_count = 3'd0; cmd_rot = 1'b0; cmd_fill = 1'b0;
    test_reset();
    test_load();
    test_shift_fill();
    test_rotate_left();
    test_count_zero();
    test_hold();
    test_back_pressure();
    test_reset_mid();
    total++; if (exp_lat.size() != 0 || exp_trace.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain: %0d/%0d entries left want 0", exp_lat.size(), exp_trace.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
